pcie_ltssm_status_decoder: RTL and testbench

- Decodes the hard-IP status bus `test_out_icm` into link-state information. The bus carries LTSSM code [4:0] and lane-activity [8:5].
- Produces a stable link-up indication, a coarse link state, a compliance flag, event pulses and saturating event counters.
- Sits beside the chaining-DMA core in the `pld_clk` domain. It feeds the LED logic and the DMA/application reset qualification.

---
 rtl/pcie_ltssm_pkg.sv | 55 +++++
 rtl/pcie_ltssm_status_decoder_sat_counter.sv | 36 +++
 rtl/pcie_ltssm_status_decoder.sv | 154 +++++++++++++++
 tb/tb_pcie_ltssm_status_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ltssm_pkg.sv
// Shared definitions for the LTSSM status decoder: code points,
// link_state encoding, FSM states and code classification.
package pcie_ltssm_pkg;

    localparam logic [4:0] DET_QUIET  = 5'h00;
    localparam logic [4:0] DET_ACT    = 5'h01;
    localparam logic [4:0] POLL_COMPL = 5'h03;
    localparam logic [4:0] RCV_LOCK   = 5'h0C;
    localparam logic [4:0] RCV_CFG    = 5'h0D;
    localparam logic [4:0] RCV_IDLE   = 5'h0E;
    localparam logic [4:0] L0         = 5'h0F;

    localparam logic [1:0] LS_DOWN  = 2'd0;
    localparam logic [1:0] LS_TRAIN = 2'd1;
    localparam logic [1:0] LS_UP    = 2'd2;
    localparam logic [1:0] LS_RECOV = 2'd3;

    typedef enum logic [2:0] {
        ST_DOWN,
        ST_TRAIN,
        ST_PEND,
        ST_UP,
        ST_RECOV
    } ltssm_st_e;

    typedef enum logic [1:0] {
        CL_DET,
        CL_L0,
        CL_RCV,
        CL_TRN
    } code_cls_e;

    function automatic code_cls_e code_class(input logic [4:0] code);
        code_cls_e c;
        unique case (1'b1)
            (code == DET_QUIET) || (code == DET_ACT): c = CL_DET;
            (code == L0):                             c = CL_L0;
            (code >= RCV_LOCK) && (code <= RCV_IDLE): c = CL_RCV;
            default:                                  c = CL_TRN;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] link_state_enc(input ltssm_st_e st);
        logic [1:0] ls;
        unique case (st)
            ST_DOWN:  ls = LS_DOWN;
            ST_UP:    ls = LS_UP;
            ST_RECOV: ls = LS_RECOV;
            default:  ls = LS_TRAIN;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/pcie_ltssm_status_decoder_sat_counter.sv
// Saturating event counter; clear wins over a coincident increment.
module pcie_sat_counter
    import pcie_ltssm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pcie_ltssm_status_decoder.sv
// Filters the hard-IP LTSSM status bus and tracks link state,
// stable link-up, event pulses and saturating event counters.
module pcie_ltssm_status_decoder
    import pcie_ltssm_pkg::*;
#(
    parameter int L0_STABLE_CYC = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             pld_clk,
    input  logic             srst,
    input  logic [8:0]       test_out_icm,
    input  logic             clr_cnt,
    output logic             link_up,
    output logic [1:0]       link_state,
    output logic             compliance,
    output logic [3:0]       lane_active,
    output logic [4:0]       ltssm_q,
    output logic             linkup_pulse,
    output logic             linkdown_pulse,
    output logic [CNT_W-1:0] l0_entry_cnt,
    output logic [CNT_W-1:0] recov_cnt,
    output logic [CNT_W-1:0] linkdown_cnt
);

    localparam logic [15:0] STAB_LAST = 16'(L0_STABLE_CYC - 1);

    logic [8:0]  raw_q,  raw_d;
    logic [8:0]  rawp_q, rawp_d;
    logic [8:0]  acc_q,  acc_d;
    ltssm_st_e   state_q, state_d;
    logic [15:0] stab_q, stab_d;
    logic        link_up_q, link_up_d;
    logic        lup_q, lup_d;
    logic        ldn_q, ldn_d;
    logic        comp_q, comp_d;
    logic        inc_l0;
    logic        inc_rcv;
    code_cls_e   cls;

    assign cls = code_class(acc_q[4:0]);

    // A code is taken only after two identical back-to-back samples.
    always_comb begin
        raw_d  = test_out_icm;
        rawp_d = raw_q;
        acc_d  = (raw_q == rawp_q) ? raw_q : acc_q;
        comp_d = (acc_q[4:0] == POLL_COMPL);
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        lup_d   = 1'b0;
        ldn_d   = 1'b0;
        inc_l0  = 1'b0;
        inc_rcv = 1'b0;
        unique case (state_q)
            ST_DOWN, ST_TRAIN: begin
                if (cls == CL_L0) begin
                    state_d = ST_PEND;
                    stab_d  = '0;
                end else if (cls == CL_DET) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_TRAIN;
                end
            end
            ST_PEND: begin
                if (cls == CL_L0) begin
                    stab_d = stab_q + 16'd1;
                    if (stab_d == STAB_LAST) begin
                        state_d = ST_UP;
                        lup_d   = 1'b1;
                        inc_l0  = 1'b1;
                    end
                end else if (cls == CL_DET) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_TRAIN;
                end
            end
            ST_UP, ST_RECOV: begin
                if (cls == CL_L0) begin
                    state_d = ST_UP;
                end else if (cls == CL_RCV) begin
                    state_d = ST_RECOV;
                    inc_rcv = (state_q == ST_UP);
                end else begin
                    state_d = (cls == CL_DET) ? ST_DOWN : ST_TRAIN;
                    ldn_d   = 1'b1;
                end
            end
            default: state_d = ST_DOWN;
        endcase
        link_up_d = (state_d == ST_UP);
    end

    always_ff @(posedge pld_clk) begin
        if (srst) begin
            raw_q     <= '0;
            rawp_q    <= '0;
            acc_q     <= '0;
            state_q   <= ST_DOWN;
            stab_q    <= '0;
            link_up_q <= 1'b0;
            lup_q     <= 1'b0;
            ldn_q     <= 1'b0;
            comp_q    <= 1'b0;
        end else begin
            raw_q     <= raw_d;
            rawp_q    <= rawp_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            stab_q    <= stab_d;
            link_up_q <= link_up_d;
            lup_q     <= lup_d;
            ldn_q     <= ldn_d;
            comp_q    <= comp_d;
        end
    end

    pcie_sat_counter #(.CNT_W(CNT_W)) u_l0_cnt (
        .clk  (pld_clk),
        .srst (srst),
        .inc  (inc_l0),
        .clr  (clr_cnt),
        .cnt  (l0_entry_cnt)
    );

    pcie_sat_counter #(.CNT_W(CNT_W)) u_recov_cnt (
        .clk  (pld_clk),
        .srst (srst),
        .inc  (inc_rcv),
        .clr  (clr_cnt),
        .cnt  (recov_cnt)
    );

    pcie_sat_counter #(.CNT_W(CNT_W)) u_ldn_cnt (
        .clk  (pld_clk),
        .srst (srst),
        .inc  (ldn_d),
        .clr  (clr_cnt),
        .cnt  (linkdown_cnt)
    );

    assign link_up        = link_up_q;
    assign link_state     = link_state_enc(state_q);
    assign compliance     = comp_q;
    assign lane_active    = acc_q[8:5];
    assign ltssm_q        = acc_q[4:0];
    assign linkup_pulse   = lup_q;
    assign linkdown_pulse = ldn_q;

endmodule

// File: tb/tb_pcie_ltssm_status_decoder.sv
// Bench for the LTSSM status decoder: directed scenarios plus random
// code sequences checked every cycle against a behavioural model.
module tb_pcie_ltssm_status_decoder;

    localparam int STAB = 16;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic       pld_clk = 1'b0;
    logic       srst = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [8:0] test_out_icm = 9'd0;

    logic          link_up;
    logic [1:0]    link_state;
    logic          compliance;
    logic [3:0]    lane_active;
    logic [4:0]    ltssm_q;
    logic          linkup_pulse;
    logic          linkdown_pulse;
    logic [CW-1:0] l0_entry_cnt;
    logic [CW-1:0] recov_cnt;
    logic [CW-1:0] linkdown_cnt;

    pcie_ltssm_status_decoder #(
        .L0_STABLE_CYC (STAB),
        .CNT_W         (CW)
    ) dut (
        .pld_clk        (pld_clk),
        .srst           (srst),
        .test_out_icm   (test_out_icm),
        .clr_cnt        (clr_cnt),
        .link_up        (link_up),
        .link_state     (link_state),
        .compliance     (compliance),
        .lane_active    (lane_active),
        .ltssm_q        (ltssm_q),
        .linkup_pulse   (linkup_pulse),
        .linkdown_pulse (linkdown_pulse),
        .l0_entry_cnt   (l0_entry_cnt),
        .recov_cnt      (recov_cnt),
        .linkdown_cnt   (linkdown_cnt)
    );

    always #5 pld_clk = ~pld_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int K_DET = 0, K_L0 = 1, K_RCV = 2, K_TRN = 3;
    localparam int S_DOWN = 0, S_TRAIN = 1, S_PEND = 2, S_UP = 3, S_RECOV = 4;

    function automatic int kind(input logic [4:0] c);
        if (c <= 5'h01) return K_DET;
        if (c == 5'h0F) return K_L0;
        if (c >= 5'h0C && c <= 5'h0E) return K_RCV;
        return K_TRN;
    endfunction

    function automatic int ls_of(input int st);
        if (st == S_DOWN) return 0;
        if (st == S_UP) return 2;
        if (st == S_RECOV) return 3;
        return 1;
    endfunction

    function automatic int bump(input int c, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && c < CMAX) return c + 1;
        return c;
    endfunction

    logic [8:0] hist[$];
    logic [8:0] m_acc = 9'd0;
    int  m_st = S_DOWN, m_age = 0, k = 0, nst = 0;
    int  m_cl0 = 0, m_crc = 0, m_cld = 0;
    bit  m_up = 0, m_upp = 0, m_dnp = 0, m_comp = 0, m_valid = 0;
    bit  e_l0 = 0, e_rc = 0, e_dn = 0;

    initial begin
        hist.push_back(9'd0);
        hist.push_back(9'd0);
    end

    always @(posedge pld_clk) begin
        if (srst) begin
            hist.delete();
            hist.push_back(9'd0);
            hist.push_back(9'd0);
            m_acc = 9'd0; m_st = S_DOWN; m_age = 0;
            m_cl0 = 0; m_crc = 0; m_cld = 0;
            m_up = 0; m_upp = 0; m_dnp = 0; m_comp = 0;
            m_valid = 1;
        end else begin
            k = kind(m_acc[4:0]);
            nst = m_st; e_l0 = 0; e_rc = 0; e_dn = 0;
            case (m_st)
                S_DOWN, S_TRAIN: begin
                    if (k == K_L0) begin nst = S_PEND; m_age = 0; end
                    else nst = (k == K_DET) ? S_DOWN : S_TRAIN;
                end
                S_PEND: begin
                    if (k == K_L0) begin
                        m_age++;
                        if (m_age == STAB - 1) begin nst = S_UP; e_l0 = 1; end
                    end else nst = (k == K_DET) ? S_DOWN : S_TRAIN;
                end
                default: begin
                    if (k == K_L0) nst = S_UP;
                    else if (k == K_RCV) begin
                        nst = S_RECOV; e_rc = (m_st == S_UP);
                    end else begin
                        nst = (k == K_DET) ? S_DOWN : S_TRAIN; e_dn = 1;
                    end
                end
            endcase
            m_upp = e_l0; m_dnp = e_dn;
            m_up = (nst == S_UP);
            m_comp = (m_acc[4:0] == 5'h03);
            m_cl0 = bump(m_cl0, e_l0, clr_cnt);
            m_crc = bump(m_crc, e_rc, clr_cnt);
            m_cld = bump(m_cld, e_dn, clr_cnt);
            m_st = nst;
            if (hist[0] == hist[1]) m_acc = hist[0];
            hist.push_front(test_out_icm);
            void'(hist.pop_back());
        end
    end

    always @(negedge pld_clk) begin
        if (m_valid) begin
            chk("m_link_state", link_state, ls_of(m_st));
            chk("m_link_up", link_up, m_up);
            chk("m_linkup_pulse", linkup_pulse, m_upp);
            chk("m_linkdown_pulse", linkdown_pulse, m_dnp);
            chk("m_compliance", compliance, m_comp);
            chk("m_ltssm_q", ltssm_q, m_acc[4:0]);
            chk("m_lane_active", lane_active, m_acc[8:5]);
            chk("m_l0_entry_cnt", l0_entry_cnt, m_cl0);
            chk("m_recov_cnt", recov_cnt, m_crc);
            chk("m_linkdown_cnt", linkdown_cnt, m_cld);
        end
    end

    // ---------------- stimulus ----------------
    int up_p = 0, dn_p = 0, n = 0;
    bit found = 0;

    task automatic step(input int cyc);
        repeat (cyc) @(posedge pld_clk);
        #1;
    endtask

    task automatic mhold(input logic [4:0] code, input logic [3:0] ln,
                         input int cyc);
        test_out_icm = {ln, code};
        repeat (cyc) begin
            step(1);
            if (linkup_pulse) up_p++;
            if (linkdown_pulse) dn_p++;
        end
    endtask

    initial begin
        logic [4:0] code;
        int len, r;
        step(3);
        srst = 1'b0;
        mhold(5'h00, 4'h0, 6);
        chk("rst_link_state", link_state, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_l0_cnt", l0_entry_cnt, 0);
        chk("rst_recov_cnt", recov_cnt, 0);
        chk("rst_ldn_cnt", linkdown_cnt, 0);

        mhold(5'h02, 4'hF, 5);
        chk("train_state", link_state, 1);
        test_out_icm = {4'hF, 5'h0F};
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            found = (ltssm_q == 5'h0F);
        end
        chk("l0_accepted", found, 1);
        n = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            n++;
            found = link_up;
        end
        chk("linkup_latency", n, 16);
        chk("linkup_pulse_hi", linkup_pulse, 1);
        step(1);
        chk("linkup_pulse_lo", linkup_pulse, 0);
        chk("l0_entry_cnt_1", l0_entry_cnt, 1);

        up_p = 0; dn_p = 0;
        mhold(5'h0C, 4'hF, 6);
        chk("recov_state", link_state, 3);
        chk("recov_link_up", link_up, 0);
        mhold(5'h0F, 4'hF, 6);
        chk("recov_back_up", link_state, 2);
        chk("recov_cnt_1", recov_cnt, 1);
        chk("recov_no_pulses", up_p + dn_p, 0);

        mhold(5'h00, 4'hF, 1);
        mhold(5'h0F, 4'hF, 6);
        chk("glitch_state", link_state, 2);
        chk("glitch_no_down", dn_p, 0);
        mhold(5'h00, 4'hF, 3);
        mhold(5'h0F, 4'hF, 5);
        chk("down_pulses", dn_p, 1);
        chk("linkdown_cnt_1", linkdown_cnt, 1);

        test_out_icm = {4'b0011, 5'h03};
        step(2);
        chk("lane_not_early", lane_active == 4'b0011, 0);
        step(1);
        chk("lane_active_3cyc", lane_active, 4'b0011);
        chk("compl_code", ltssm_q, 5'h03);
        step(1);
        chk("compliance", compliance, 1);
        chk("compl_state", link_state, 1);

        mhold(5'h0F, 4'hF, 24);
        chk("up_again", link_up, 1);
        repeat (5) begin
            mhold(5'h0C, 4'hF, 3);
            mhold(5'h0F, 4'hF, 3);
        end
        mhold(5'h0F, 4'hF, 4);
        chk("recov_sat", recov_cnt, 3);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("clr_recov", recov_cnt, 0);
        chk("clr_l0", l0_entry_cnt, 0);
        chk("clr_ldn", linkdown_cnt, 0);

        test_out_icm = {4'hF, 5'h0C};
        step(3);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("clr_inc_state", link_state, 3);
        chk("clr_beats_inc", recov_cnt, 0);
        mhold(5'h0F, 4'hF, 4);
        chk("up_after_clr", link_state, 2);

        mhold(5'h00, 4'hF, 6);
        mhold(5'h0F, 4'hF, 8);
        chk("pend_state", link_state, 1);
        chk("pend_no_up", link_up, 0);
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        chk("srst_state", link_state, 0);
        chk("srst_up_p", linkup_pulse, 0);
        chk("srst_dn_p", linkdown_pulse, 0);
        chk("srst_ltssm", ltssm_q, 0);
        chk("srst_ldn_cnt", linkdown_cnt, 0);

        for (int s = 0; s < 900; s++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: code = 5'h00;
                1: code = 5'h01;
                2: code = 5'h02;
                3: code = 5'h03;
                4: code = 5'h0C;
                5: code = 5'h0D;
                6: code = 5'h0E;
                9: code = 5'($urandom_range(0, 31));
                default: code = 5'h0F;
            endcase
            if (code == 5'h0F && $urandom_range(0, 1) == 1)
                len = $urandom_range(14, 24);
            else
                len = $urandom_range(1, 4);
            test_out_icm = {4'($urandom_range(0, 15)), code};
            clr_cnt = ($urandom_range(0, 29) == 0);
            srst = ($urandom_range(0, 299) == 0);
            step(1);
            clr_cnt = 1'b0;
            srst = 1'b0;
            if (len > 1) step(len - 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
